// File: rtl/gabor_pkg.sv
// Shared constants, types, scan-state encoding and the four Q15 Gabor kernels.
// Kernel tables are row-major: index 0 = top-left tap, index 24 = bottom-right tap.
package gabor_pkg;

    localparam int unsigned IMG_W      = 512;
    localparam int unsigned IMG_H      = 512;
    localparam int unsigned ROW_STRIDE = 516;
    localparam int unsigned PIX_W      = 10;
    localparam int unsigned COEF_W     = 16;
    localparam int unsigned ACC_W      = 34;
    localparam int unsigned ADDR_W     = 19;
    // Zero-extended pixel (PIX_W+1) times coefficient (COEF_W).
    localparam int unsigned PROD_W     = PIX_W + COEF_W + 1;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [PROD_W-1:0] prod_t;

    typedef enum logic {ST_RUN, ST_DONE} state_t;

    localparam coef_t C_45 [25] = '{
        -16'sd500,  -16'sd1500,  16'sd0,     16'sd5000,  16'sd12000,
        -16'sd1500,  16'sd0,     16'sd5000,  16'sd12000, 16'sd5000,
         16'sd0,     16'sd5000,  16'sd12000, 16'sd5000,  16'sd0,
         16'sd5000,  16'sd12000, 16'sd5000,  16'sd0,    -16'sd1500,
         16'sd12000, 16'sd5000,  16'sd0,    -16'sd1500, -16'sd500
    };

    localparam coef_t C_90 [25] = '{
        -16'sd2000, -16'sd6000,  -16'sd8000,  -16'sd6000,  -16'sd2000,
         16'sd3000,  16'sd9000,   16'sd12000,  16'sd9000,   16'sd3000,
         16'sd8000,  16'sd24000,  16'sd32000,  16'sd24000,  16'sd8000,
         16'sd3000,  16'sd9000,   16'sd12000,  16'sd9000,   16'sd3000,
        -16'sd2000, -16'sd6000,  -16'sd8000,  -16'sd6000,  -16'sd2000
    };

    localparam coef_t C_135 [25] = '{
         16'sd20000,  16'sd4000,  -16'sd6000, -16'sd2500,  16'sd300,
         16'sd4000,   16'sd20000,  16'sd4000, -16'sd6000, -16'sd2500,
        -16'sd6000,   16'sd4000,   16'sd20000, 16'sd4000, -16'sd6000,
        -16'sd2500,  -16'sd6000,   16'sd4000,  16'sd20000, 16'sd4000,
         16'sd300,   -16'sd2500,  -16'sd6000,  16'sd4000,  16'sd20000
    };

    localparam coef_t C_180 [25] = '{
        -16'sd2000,  16'sd3000,  16'sd8000,  16'sd3000, -16'sd2000,
        -16'sd6000,  16'sd9000,  16'sd24000, 16'sd9000, -16'sd6000,
        -16'sd8000,  16'sd12000, 16'sd32000, 16'sd12000, -16'sd8000,
        -16'sd6000,  16'sd9000,  16'sd24000, 16'sd9000, -16'sd6000,
        -16'sd2000,  16'sd3000,  16'sd8000,  16'sd3000, -16'sd2000
    };

endpackage

// File: rtl/gabor_conv5x5_mac25.sv
// 25-tap multiply-accumulate: registered products, then 5 row sums, then total.
// Ports: clk/rst; en_prod/en_row/en_sum advance each stage; pix/coef are the
// window and kernel taps (row-major); sum is the registered signed total.
module gabor_mac25
    import gabor_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_prod,
    input  logic  en_row,
    input  logic  en_sum,
    input  pix_t  pix  [25],
    input  coef_t coef [25],
    output acc_t  sum
);

    prod_t prod_q [25];
    acc_t  row_q  [5];

    // Three enabled stages; each holds its value until the next enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 25; i++) prod_q[i] <= '0;
            for (int r = 0; r < 5; r++)  row_q[r]  <= '0;
            sum <= '0;
        end else begin
            if (en_prod) begin
                for (int i = 0; i < 25; i++)
                    prod_q[i] <= PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(coef[i]);
            end
            if (en_row) begin
                for (int r = 0; r < 5; r++)
                    row_q[r] <= ACC_W'(prod_q[5*r])   + ACC_W'(prod_q[5*r+1]) +
                                ACC_W'(prod_q[5*r+2]) + ACC_W'(prod_q[5*r+3]) +
                                ACC_W'(prod_q[5*r+4]);
            end
            if (en_sum)
                sum <= row_q[0] + row_q[1] + row_q[2] + row_q[3] + row_q[4];
        end
    end

endmodule

// File: rtl/gabor_conv5x5.sv
// 5x5 Gabor filter bank (45/90/135/180 degrees) over a padded image BRAM.
// Ports: clk, rst (async, active-high); pixel1..pixel25 window pixels for
// image_BRAM_addr (row-major); add_out_* signed kernel sums; data_ready is a
// one-cycle pulse when all four sums are valid.
module gabor_conv5x5
    import gabor_pkg::*;
#(
    parameter int unsigned SCAN_W = IMG_W,
    parameter int unsigned SCAN_H = IMG_H,
    parameter int unsigned STRIDE = ROW_STRIDE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PIX_W-1:0]  pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
    input  logic [PIX_W-1:0]  pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
    input  logic [PIX_W-1:0]  pixel11, pixel12, pixel13, pixel14, pixel15,
    input  logic [PIX_W-1:0]  pixel16, pixel17, pixel18, pixel19, pixel20,
    input  logic [PIX_W-1:0]  pixel21, pixel22, pixel23, pixel24, pixel25,
    output logic [ACC_W-1:0]  add_out_45_5,
    output logic [ACC_W-1:0]  add_out_90,
    output logic [ACC_W-1:0]  add_out_135,
    output logic [ACC_W-1:0]  add_out_180,
    output logic              data_ready,
    output logic [ADDR_W-1:0] image_BRAM_addr
);

    state_t      state_q, state_d;
    logic        phase;
    logic        v1, v2;
    logic [15:0] col, row;
    logic        capture_c, advance_c, last_c;
    pix_t        pix_w [25];

    assign pix_w = '{pixel1,  pixel2,  pixel3,  pixel4,  pixel5,
                     pixel6,  pixel7,  pixel8,  pixel9,  pixel10,
                     pixel11, pixel12, pixel13, pixel14, pixel15,
                     pixel16, pixel17, pixel18, pixel19, pixel20,
                     pixel21, pixel22, pixel23, pixel24, pixel25};

    assign last_c = (col == 16'(SCAN_W - 1)) && (row == 16'(SCAN_H - 1));

    // Phase 0 captures the window at the current address; phase 1 moves on.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        advance_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                capture_c = ~phase;
                if (phase) begin
                    if (last_c) state_d   = ST_DONE;
                    else        advance_c = 1'b1;
                end
            end
            ST_DONE: ;
            default: state_d = ST_RUN;
        endcase
    end

    // Scan controller and valid pipeline matching the MAC stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            phase           <= 1'b0;
            col             <= '0;
            row             <= '0;
            image_BRAM_addr <= '0;
            v1              <= 1'b0;
            v2              <= 1'b0;
            data_ready      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase      <= ~phase;
            v1         <= capture_c;
            v2         <= v1;
            data_ready <= v2;
            if (advance_c) begin
                if (col == 16'(SCAN_W - 1)) begin
                    // Jump over the pad words to the start of the next row.
                    col             <= '0;
                    row             <= row + 16'd1;
                    image_BRAM_addr <= image_BRAM_addr + ADDR_W'(STRIDE - SCAN_W + 1);
                end else begin
                    col             <= col + 16'd1;
                    image_BRAM_addr <= image_BRAM_addr + ADDR_W'(1);
                end
            end
        end
    end

    gabor_mac25 u_mac_45 (
        .clk(clk), .rst(rst), .en_prod(capture_c), .en_row(v1), .en_sum(v2),
        .pix(pix_w), .coef(C_45), .sum(add_out_45_5)
    );
    gabor_mac25 u_mac_90 (
        .clk(clk), .rst(rst), .en_prod(capture_c), .en_row(v1), .en_sum(v2),
        .pix(pix_w), .coef(C_90), .sum(add_out_90)
    );
    gabor_mac25 u_mac_135 (
        .clk(clk), .rst(rst), .en_prod(capture_c), .en_row(v1), .en_sum(v2),
        .pix(pix_w), .coef(C_135), .sum(add_out_135)
    );
    gabor_mac25 u_mac_180 (
        .clk(clk), .rst(rst), .en_prod(capture_c), .en_row(v1), .en_sum(v2),
        .pix(pix_w), .coef(C_180), .sum(add_out_180)
    );

endmodule

// File: tb/tb_gabor_conv5x5.sv
// Directed bench for gabor_conv5x5: reset, scan order, zero/impulse/constant
// images, mid-run reset, and end-of-scan idle on a reduced-size instance.
module tb_gabor_conv5x5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_s;
    int          mode;
    logic [9:0]  pix [25];
    logic [9:0]  one_pix;

    logic signed [33:0] o45, o90, o135, o180;
    logic signed [33:0] s45, s90, s135, s180;
    logic        dr, s_dr;
    logic [18:0] addr, s_addr;

    int total  = 0;
    int passed = 0;

    // Memory model: 0 = all zero, 1 = single 255 at word 1034, 2 = constant 200.
    function automatic logic [9:0] pix_at(input int m, input int a);
        case (m)
            1:       return (a == 1034) ? 10'd255 : 10'd0;
            2:       return 10'd200;
            default: return 10'd0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 25; i++)
            pix[i] = pix_at(mode, int'(addr) + (i / 5) * 516 + (i % 5));
    end

    assign one_pix = 10'd1;

    gabor_conv5x5 dut (
        .clk(clk), .rst(rst),
        .pixel1(pix[0]),   .pixel2(pix[1]),   .pixel3(pix[2]),   .pixel4(pix[3]),   .pixel5(pix[4]),
        .pixel6(pix[5]),   .pixel7(pix[6]),   .pixel8(pix[7]),   .pixel9(pix[8]),   .pixel10(pix[9]),
        .pixel11(pix[10]), .pixel12(pix[11]), .pixel13(pix[12]), .pixel14(pix[13]), .pixel15(pix[14]),
        .pixel16(pix[15]), .pixel17(pix[16]), .pixel18(pix[17]), .pixel19(pix[18]), .pixel20(pix[19]),
        .pixel21(pix[20]), .pixel22(pix[21]), .pixel23(pix[22]), .pixel24(pix[23]), .pixel25(pix[24]),
        .add_out_45_5(o45), .add_out_90(o90), .add_out_135(o135), .add_out_180(o180),
        .data_ready(dr), .image_BRAM_addr(addr)
    );

    gabor_conv5x5 #(.SCAN_W(4), .SCAN_H(3), .STRIDE(8)) dut_small (
        .clk(clk), .rst(rst_s),
        .pixel1(one_pix),  .pixel2(one_pix),  .pixel3(one_pix),  .pixel4(one_pix),  .pixel5(one_pix),
        .pixel6(one_pix),  .pixel7(one_pix),  .pixel8(one_pix),  .pixel9(one_pix),  .pixel10(one_pix),
        .pixel11(one_pix), .pixel12(one_pix), .pixel13(one_pix), .pixel14(one_pix), .pixel15(one_pix),
        .pixel16(one_pix), .pixel17(one_pix), .pixel18(one_pix), .pixel19(one_pix), .pixel20(one_pix),
        .pixel21(one_pix), .pixel22(one_pix), .pixel23(one_pix), .pixel24(one_pix), .pixel25(one_pix),
        .add_out_45_5(s45), .add_out_90(s90), .add_out_135(s135), .add_out_180(s180),
        .data_ready(s_dr), .image_BRAM_addr(s_addr)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart(input int m);
        mode = m;
        rst  = 1'b1;
        tick();
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset;
        logic exp;
        rst = 1'b1;
        mode = 0;
        repeat (10) tick();
        total++;
        if (addr !== 19'd0) $display("FAIL reset_addr got %0d want 0", addr);
        else passed++;
        total++;
        if (dr !== 1'b0) $display("FAIL reset_ready got %b want 0", dr);
        else passed++;
        total++;
        if ({o45, o90, o135, o180} !== 136'd0)
            $display("FAIL reset_sums got %0d %0d %0d %0d want 0", o45, o90, o135, o180);
        else passed++;
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp = (t >= 3) && (t % 2 == 1);
            total++;
            if (dr !== exp) $display("FAIL ready_timing edge %0d got %b want %b", t, dr, exp);
            else passed++;
        end
    endtask

    task automatic test_zero_scan;
        int k;
        int exp_addr;
        restart(0);
        for (int t = 1; t <= 1210; t++) begin
            tick();
            if (t % 2 == 0) begin
                k = t / 2;
                exp_addr = (k / 512) * 516 + (k % 512);
                total++;
                if (addr !== 19'(exp_addr)) $display("FAIL scan_addr k=%0d got %0d want %0d", k, addr, exp_addr);
                else passed++;
                if (k == 512) begin
                    total++;
                    if (addr !== 19'd516) $display("FAIL row_wrap_addr got %0d want 516", addr);
                    else passed++;
                end
            end
            if (t % 2 == 1 && t >= 3) begin
                total++;
                if ({dr, o45, o90, o135, o180} !== {1'b1, 136'd0})
                    $display("FAIL zero_result edge %0d ready %b sums %0d %0d %0d %0d want 1 and 0", t, dr, o45, o90, o135, o180);
                else passed++;
            end else begin
                total++;
                if (dr !== 1'b0) $display("FAIL zero_gap edge %0d got %b want 0", t, dr);
                else passed++;
            end
        end
    endtask

    task automatic test_impulse;
        restart(1);
        repeat (3) tick();
        total++;
        if ({dr, o45, o90, o135, o180} !== {1'b1, 34'sd3060000, 34'sd8160000, 34'sd5100000, 34'sd8160000})
            $display("FAIL impulse_res0 got %b %0d %0d %0d %0d want 1 3060000 8160000 5100000 8160000", dr, o45, o90, o135, o180);
        else passed++;
        repeat (2) tick();
        total++;
        if ({o45, o90, o135, o180} !== {34'sd1275000, 34'sd6120000, 34'sd1020000, 34'sd3060000})
            $display("FAIL impulse_res1 got %0d %0d %0d %0d want 1275000 6120000 1020000 3060000", o45, o90, o135, o180);
        else passed++;
        repeat (2) tick();
        total++;
        if ({o45, o90, o135, o180} !== {34'sd0, 34'sd2040000, -34'sd1530000, -34'sd2040000})
            $display("FAIL impulse_res2 got %0d %0d %0d %0d want 0 2040000 -1530000 -2040000", o45, o90, o135, o180);
        else passed++;
        repeat (2) tick();
        total++;
        if ({o45, o90, o135, o180} !== 136'd0)
            $display("FAIL impulse_res3 got %0d %0d %0d %0d want 0", o45, o90, o135, o180);
        else passed++;
    endtask

    task automatic test_constant;
        restart(2);
        repeat (3) tick();
        total++;
        if ({o45, o90, o135, o180} !== {34'sd18600000, 34'sd24000000, 34'sd17320000, 34'sd24000000})
            $display("FAIL const_sums got %0d %0d %0d %0d want 18600000 24000000 17320000 24000000", o45, o90, o135, o180);
        else passed++;
        total++;
        if ({o45[22:15], o90[22:15], o135[22:15], o180[22:15]} !== {8'd55, 8'd220, 8'd16, 8'd220})
            $display("FAIL const_bytes got %0d %0d %0d %0d want 55 220 16 220", o45[22:15], o90[22:15], o135[22:15], o180[22:15]);
        else passed++;
        repeat (40) tick();
        total++;
        if ({dr, o135} !== {1'b1, 34'sd17320000})
            $display("FAIL const_later got %b %0d want 1 17320000", dr, o135);
        else passed++;
    endtask

    task automatic test_mid_reset;
        int cnt = 0;
        restart(1);
        for (int t = 1; t <= 201; t++) begin
            tick();
            if (dr === 1'b1) cnt++;
        end
        total++;
        if (cnt !== 100) $display("FAIL midrst_count got %0d want 100", cnt);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({dr, addr} !== {1'b0, 19'd0}) $display("FAIL midrst_async got %b %0d want 0 0", dr, addr);
        else passed++;
        tick();
        tick();
        total++;
        if (dr !== 1'b0) $display("FAIL midrst_hold got %b want 0", dr);
        else passed++;
        rst = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            tick();
            total++;
            if (dr !== 1'b0) $display("FAIL midrst_stray edge %0d got %b want 0", t, dr);
            else passed++;
        end
        tick();
        total++;
        if ({dr, o90, o180} !== {1'b1, 34'sd8160000, 34'sd8160000})
            $display("FAIL midrst_res0 got %b %0d %0d want 1 8160000 8160000", dr, o90, o180);
        else passed++;
        repeat (2) tick();
        total++;
        if ({dr, o90, addr} !== {1'b1, 34'sd6120000, 19'd2})
            $display("FAIL midrst_res1 got %b %0d %0d want 1 6120000 2", dr, o90, addr);
        else passed++;
    endtask

    task automatic test_small_run;
        int cnt = 0;
        rst_s = 1'b1;
        tick();
        tick();
        rst_s = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (s_dr === 1'b1) begin
                cnt++;
                if (cnt == 1) begin
                    total++;
                    if ({s45, s90, s135, s180} !== {34'sd93000, 34'sd120000, 34'sd86600, 34'sd120000})
                        $display("FAIL small_sums got %0d %0d %0d %0d want 93000 120000 86600 120000", s45, s90, s135, s180);
                    else passed++;
                end
            end
        end
        total++;
        if (cnt !== 12) $display("FAIL small_count got %0d want 12", cnt);
        else passed++;
        total++;
        if (s_addr !== 19'd19) $display("FAIL small_last_addr got %0d want 19", s_addr);
        else passed++;
        cnt = 0;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (s_dr === 1'b1) cnt++;
        end
        total++;
        if ({cnt, s_addr} !== {32'd0, 19'd19}) $display("FAIL small_idle pulses %0d addr %0d want 0 19", cnt, s_addr);
        else passed++;
    endtask

    initial begin
        rst   = 1'b1;
        rst_s = 1'b1;
        mode  = 0;
        test_reset();
        test_zero_scan();
        test_impulse();
        test_constant();
        test_mid_reset();
        test_small_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
